// File: rtl/cond_unit.sv
// Conditional-execution unit for the single-cycle ARM datapath: holds the
// N/Z/C/V flag register, evaluates condition fields and gates write strobes.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCount
);

  logic flagN;
  logic flagZ;
  logic flagC;
  logic flagV;
  logic signedGe;
  logic baseTrue;
  logic alwaysCode;
  logic advance;
  logic squash;
  logic counterFull;

  assign flagN    = Flags[3];
  assign flagZ    = Flags[2];
  assign flagC    = Flags[1];
  assign flagV    = Flags[0];
  assign signedGe = (flagN == flagV);

  // Each even code has an odd partner that is its exact complement, so only
  // the eight base predicates are decoded and Cond[0] inverts the result.
  always_comb begin
    baseTrue = 1'b1;
    unique case (Cond[3:1])
      3'd0:    baseTrue = flagZ;
      3'd1:    baseTrue = flagC;
      3'd2:    baseTrue = flagN;
      3'd3:    baseTrue = flagV;
      3'd4:    baseTrue = flagC & ~flagZ;
      3'd5:    baseTrue = signedGe;
      3'd6:    baseTrue = ~flagZ & signedGe;
      default: baseTrue = 1'b1;
    endcase
  end

  // Codes 1110 and 1111 both execute unconditionally.
  assign alwaysCode = (Cond[3:1] == 3'b111);
  assign CondEx     = alwaysCode | (baseTrue ^ Cond[0]);

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

  assign advance     = en & CondEx;
  assign squash      = en & ~CondEx;
  assign counterFull = &SquashCount;

  // The N/Z and C/V halves are written independently by FlagW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags <= 4'b0000;
    end else if (advance) begin
      if (FlagW[1]) begin
        Flags[3:2] <= ALUFlags[3:2];
      end
      if (FlagW[0]) begin
        Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Debug count of squashed instructions; sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SquashCount <= '0;
    end else if (squash && !counterFull) begin
      SquashCount <= SquashCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a behavioural flag/counter model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cond_unit;

  localparam int CNT_W   = 4;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCount;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [3:0] modelFlags;
  int         modelSquash;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  // Architectural condition table written from the mnemonic definitions.
  function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modelFlags  <= 4'b0000;
      modelSquash <= 0;
    end else if (en) begin
      if (modelCond(Cond, modelFlags)) begin
        modelFlags <= {FlagW[1] ? ALUFlags[3:2] : modelFlags[3:2],
                       FlagW[0] ? ALUFlags[1:0] : modelFlags[1:0]};
      end else begin
        modelSquash <= (modelSquash == SAT_MAX) ? SAT_MAX : modelSquash + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] c, input logic [3:0] a,
                               input logic [1:0] fw, input logic p, input logic r,
                               input logic m, input logic nw);
    @(negedge clk);
    #1;
    en = e; Cond = c; ALUFlags = a; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw;
  endtask

  // Every negedge, compare all outputs against the model.
  always @(negedge clk) begin
    logic expEx;
    expEx = modelCond(Cond, modelFlags);
    checkOutput("modelCondEx",   {31'd0, CondEx},   {31'd0, expEx});
    checkOutput("modelPCSrc",    {31'd0, PCSrc},    {31'd0, PCS & expEx});
    checkOutput("modelRegWrite", {31'd0, RegWrite}, {31'd0, RegW & expEx & ~NoWrite});
    checkOutput("modelMemWrite", {31'd0, MemWrite}, {31'd0, MemW & expEx});
    checkOutput("modelFlags",    {28'd0, Flags},    {28'd0, modelFlags});
    checkOutput("modelSquash",   {28'd0, SquashCount}, modelSquash);
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    #1 checkOutput("resetFlags", {28'd0, Flags}, 32'h0);
    checkOutput("resetSquash", {28'd0, SquashCount}, 32'h0);
    Cond = 4'h0;
    #1 checkOutput("resetEqFails", {31'd0, CondEx}, 32'd0);
    Cond = 4'h1;
    #1 checkOutput("resetNePasses", {31'd0, CondEx}, 32'd1);

    // CMP then BEQ with no bubble
    applyStimulus(1, 4'hE, 4'h6, 2'b11, 0, 1, 0, 1);
    #1 checkOutput("cmpRegWrite", {31'd0, RegWrite}, 32'd0);
    @(posedge clk); #1 checkOutput("cmpFlags", {28'd0, Flags}, 32'h6);
    applyStimulus(1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    #1 checkOutput("beqCondEx", {31'd0, CondEx}, 32'd1);
    checkOutput("beqPCSrc", {31'd0, PCSrc}, 32'd1);

    // Partial flag updates
    applyStimulus(1, 4'hE, 4'h9, 2'b11, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("partialStart", {28'd0, Flags}, 32'h9);
    applyStimulus(1, 4'hE, 4'h6, 2'b10, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("partialNZ", {28'd0, Flags}, 32'h5);
    applyStimulus(1, 4'hE, 4'hA, 2'b01, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("partialCV", {28'd0, Flags}, 32'h6);

    // Failed condition squashes the update and the memory write
    applyStimulus(1, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 4'hF, 2'b11, 0, 0, 1, 0);
    #1 checkOutput("failMemWrite", {31'd0, MemWrite}, 32'd0);
    @(posedge clk); #1 checkOutput("failFlags", {28'd0, Flags}, 32'h0);
    checkOutput("failSquash", {28'd0, SquashCount}, 32'h1);

    // Stall holds all state
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'h0, 4'hF, 2'b11, 0, 0, 0, 0);
      @(posedge clk); #1 checkOutput("stallFlags", {28'd0, Flags}, 32'h0);
      checkOutput("stallSquash", {28'd0, SquashCount}, 32'h1);
    end

    // Full sweep: flags x condition, strobes varied per code
    for (int f = 0; f < 16; f++) begin
      applyStimulus(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(0, 4'(c), 4'h0, 2'b11, c[0], c[1], c[2], c[3] ^ f[0]);
      end
    end

    // Signed-compare spot checks
    applyStimulus(1, 4'hE, 4'h8, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
    #1 checkOutput("spotGe1000", {31'd0, CondEx}, 32'd0);
    applyStimulus(0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
    #1 checkOutput("spotLt1000", {31'd0, CondEx}, 32'd1);
    applyStimulus(1, 4'hE, 4'h9, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
    #1 checkOutput("spotGt1001", {31'd0, CondEx}, 32'd1);
    applyStimulus(1, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 4'hD, 4'h0, 2'b00, 0, 0, 0, 0);
    #1 checkOutput("spotLe0100", {31'd0, CondEx}, 32'd1);

    // Saturation: NE fails with Z set
    repeat (20) applyStimulus(1, 4'h1, 4'h0, 2'b11, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("satReached", {28'd0, SquashCount}, 32'hF);
    repeat (2) applyStimulus(1, 4'h1, 4'h0, 2'b11, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("satHolds", {28'd0, SquashCount}, 32'hF);
    checkOutput("satFlagsHeld", {28'd0, Flags}, 32'h4);

    // Reset mid-cycle with a pending update
    applyStimulus(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
    applyStimulus(1, 4'hE, 4'h5, 2'b11, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 checkOutput("midResetFlags", {28'd0, Flags}, 32'h0);
    checkOutput("midResetSquash", {28'd0, SquashCount}, 32'h0);
    Cond = 4'h0;
    #1 checkOutput("midResetEq", {31'd0, CondEx}, 32'd0);
    Cond = 4'h1;
    #1 checkOutput("midResetNe", {31'd0, CondEx}, 32'd1);
    Cond = 4'hE;
    @(posedge clk); #1 checkOutput("midResetHeld", {28'd0, Flags}, 32'h0);
    @(negedge clk); #1 reset_n = 1'b1;
    applyStimulus(1, 4'hE, 4'h3, 2'b11, 0, 0, 0, 0);
    @(posedge clk); #1 checkOutput("postResetUpdate", {28'd0, Flags}, 32'h3);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
